// File: rtl/y_serializer.sv
// Purpose : buffers 12-bit results in a small FIFO and sends each one as a UART-style frame on sout.
// Latency : a push into an empty, idle block starts its start bit on the next clock edge.
// Backpressure: none upstream; a push into a full FIFO without a same-edge pop is dropped and sets overflow.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   y_in, y_valid   - result word and its one-cycle push strobe
//   sout, sframe    - serial line (idles high) and frame-active flag, both registered
//   full, busy      - FIFO full; FSM active or FIFO non-empty
//   overflow        - sticky flag, set when a push is dropped
// Parameters: DEPTH (power of two, 2..16), DIV (cycles per serial bit, 1..255)
// Build option: define Y_SERIALIZER_PARITY_EN to add an even-parity bit before the stop bit.
module y_serializer #(
  parameter int DEPTH = 4,
  parameter int DIV   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] y_in,
  input  logic        y_valid,
  output logic        sout,
  output logic        sframe,
  output logic        full,
  output logic        busy,
  output logic        overflow
);

  localparam int              AW        = $clog2(DEPTH);
  localparam logic [7:0]      DIV_LAST  = 8'(DIV - 1);
  localparam logic [AW:0]     DEPTH_CNT = DEPTH[AW:0];
  localparam logic [AW-1:0]   PTR_ONE   = 1;
  localparam logic [AW:0]     CNT_ONE   = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef Y_SERIALIZER_PARITY_EN
    S_PAR,
`endif
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    div_cnt_q, div_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [11:0]   shreg_q, shreg_d;
  logic          sout_q, sout_d;
  logic          sframe_q, sframe_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
`ifdef Y_SERIALIZER_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [11:0]   mem_q [DEPTH];

  logic          bit_end;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic [11:0]   head;

  assign bit_end    = (div_cnt_q == DIV_LAST);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign head       = mem_q[rd_ptr_q];

  // A word leaves the FIFO either from IDLE or on the last cycle of a stop bit,
  // so consecutive frames run with no idle gap.
  assign pop  = !fifo_empty &&
                ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));
  assign push = y_valid && (!fifo_full || pop);

  // Frame sequencing and next-state values
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
`ifdef Y_SERIALIZER_PARITY_EN
    par_d     = par_q;
`endif

    if (state_q != S_IDLE) begin
      div_cnt_d = bit_end ? 8'd0 : div_cnt_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d   = S_START;
          div_cnt_d = 8'd0;
          shreg_d   = head;
`ifdef Y_SERIALIZER_PARITY_EN
          par_d     = ^head;
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = 4'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 4'd11) begin
`ifdef Y_SERIALIZER_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shreg_d   = {shreg_q[10:0], 1'b0};
          end
        end
      end
`ifdef Y_SERIALIZER_PARITY_EN
      S_PAR: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (pop) begin
            state_d = S_START;
            shreg_d = head;
`ifdef Y_SERIALIZER_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line outputs are derived from the next state so they can be registered
  // and still line up exactly with the state they belong to.
  always_comb begin
    sout_d   = 1'b1;
    sframe_d = (state_d != S_IDLE);
    case (state_d)
      S_START: sout_d = 1'b0;
      S_DATA:  sout_d = shreg_d[11];
`ifdef Y_SERIALIZER_PARITY_EN
      S_PAR:   sout_d = par_d;
`endif
      default: sout_d = 1'b1;
    endcase
  end

  // FIFO pointers, occupancy and overflow flag
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - CNT_ONE;
    end
    overflow_d = overflow_q | (y_valid & !push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= 8'd0;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 12'd0;
      sout_q     <= 1'b1;
      sframe_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef Y_SERIALIZER_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      sout_q     <= sout_d;
      sframe_q   <= sframe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef Y_SERIALIZER_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Storage is not reset: occupancy going to zero discards its contents.
  // When full with a same-edge pop, write and read hit the same slot; the pop
  // captures the old word before the new one lands.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= y_in;
    end
  end

  assign sout     = sout_q;
  assign sframe   = sframe_q;
  assign full     = fifo_full;
  assign busy     = (state_q != S_IDLE) || !fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_y_serializer.sv
// Bench for y_serializer: two instances (DIV=1 and DIV=3, DEPTH=4) share the
// same stimulus; each is compared every cycle against a frame-level model that
// keeps the waiting words and the expected line values of the frame in flight.
module tb_y_serializer;

  localparam int DEPTH = 4;
`ifdef Y_SERIALIZER_PARITY_EN
  localparam int FB = 15;
`else
  localparam int FB = 14;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] y_in = 12'd0;
  logic        y_valid = 1'b0;
  logic [1:0]  sout, sframe, full, busy, overflow;

  int checks = 0;
  int errors = 0;

  // Model state per instance
  bit          exp_bits [2][$];
  logic [11:0] exp_fifo [2][$];
  bit          exp_ovf  [2];
  int          run_len  [2];
  int          last_run [2];

  always #5 clk = ~clk;

  y_serializer #(.DEPTH(DEPTH), .DIV(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_valid(y_valid),
    .sout(sout[0]), .sframe(sframe[0]), .full(full[0]), .busy(busy[0]),
    .overflow(overflow[0])
  );

  y_serializer #(.DEPTH(DEPTH), .DIV(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .y_in(y_in), .y_valid(y_valid),
    .sout(sout[1]), .sframe(sframe[1]), .full(full[1]), .busy(busy[1]),
    .overflow(overflow[1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_bits[i].delete();
      exp_fifo[i].delete();
      exp_ovf[i]  = 1'b0;
      run_len[i]  = 0;
      last_run[i] = 0;
    end
  endtask

  // One clock edge: the cycle just shown is consumed; if the line is then
  // free, the oldest waiting word becomes a whole frame of line values.
  // A push is accepted whenever room exists after that pop.
  task automatic model_edge(input int i, input bit v, input logic [11:0] d);
    logic [11:0] w;
    bit          fb;
    if (exp_bits[i].size() != 0) void'(exp_bits[i].pop_front());
    if (exp_bits[i].size() == 0 && exp_fifo[i].size() != 0) begin
      w = exp_fifo[i].pop_front();
      for (int b = 0; b < FB; b++) begin
        if (b == 0)           fb = 1'b0;
        else if (b <= 12)     fb = w[12 - b];
        else if (b == FB - 1) fb = 1'b1;
        else                  fb = ^w;
        for (int r = 0; r < div_of(i); r++) exp_bits[i].push_back(fb);
      end
    end
    if (v) begin
      if (exp_fifo[i].size() < DEPTH) exp_fifo[i].push_back(d);
      else                            exp_ovf[i] = 1'b1;
    end
  endtask

  task automatic check_all();
    bit e_act;
    for (int i = 0; i < 2; i++) begin
      e_act = (exp_bits[i].size() != 0);
      check_val($sformatf("sout%0d", i),     sout[i],     e_act ? exp_bits[i][0] : 1'b1);
      check_val($sformatf("sframe%0d", i),   sframe[i],   e_act);
      check_val($sformatf("full%0d", i),     full[i],     exp_fifo[i].size() == DEPTH);
      check_val($sformatf("busy%0d", i),     busy[i],     e_act || (exp_fifo[i].size() != 0));
      check_val($sformatf("overflow%0d", i), overflow[i], exp_ovf[i]);
      if (sframe[i]) begin
        run_len[i]++;
      end else if (run_len[i] != 0) begin
        last_run[i] = run_len[i];
        run_len[i]  = 0;
      end
    end
  endtask

  task automatic step(input bit v, input logic [11:0] d);
    y_valid = v;
    y_in    = d;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, v, d);
    #1;
    check_all();
    y_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    y_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_bits[0].size() != 0 || exp_fifo[0].size() != 0 ||
            exp_bits[1].size() != 0 || exp_fifo[1].size() != 0) && guard < 3000) begin
      step(1'b0, 12'd0);
      guard++;
    end
    check_val("drain_timeout", guard < 3000, 1'b1);
    step(1'b0, 12'd0);
  endtask

  initial begin
    int guard;

    // Reset state and single word
    do_reset();
    step(1'b1, 12'hA5C);
    drain();
    check_val("a5c_len0", last_run[0], FB);
    check_val("a5c_len1", last_run[1], 3 * FB);

    // All ones (negative), parity bit 0 when enabled
    step(1'b1, 12'hFFF);
    drain();
    check_val("fff_len1", last_run[1], 3 * FB);

    // Back-to-back frames
    step(1'b1, 12'h001);
    step(1'b1, 12'h800);
    drain();
    check_val("b2b_len0", last_run[0], 2 * FB);
    check_val("b2b_len1", last_run[1], 6 * FB);

    // Overflow: six consecutive pushes from idle
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 12'(12'h111 * (k + 1)));
      if (k == 4) check_val("full_after5", full[0], 1'b1);
    end
    check_val("ovf_after6", overflow[0], 1'b1);
    drain();
    check_val("ovf_sticky", overflow[0], 1'b1);

    // Push while full on the stop-to-start pop edge
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 12'(12'h0F0 + k));
    check_val("full_before_pop", full[0], 1'b1);
    guard = 0;
    while (exp_bits[0].size() != 1 && guard < 200) begin
      step(1'b0, 12'd0);
      guard++;
    end
    check_val("pop_edge_timeout", guard < 200, 1'b1);
    step(1'b1, 12'h3C3);
    check_val("pop_push_ovf", overflow[0], 1'b0);
    check_val("pop_push_full", full[0], 1'b1);
    drain();

    // Reset during the 5th data bit of the DIV=1 instance
    do_reset();
    step(1'b1, 12'h5A5);
    for (int k = 0; k < 6; k++) step(1'b0, 12'd0);
    check_val("mid_sframe_before", sframe[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_async_sout", sout[0], 1'b1);
    check_val("rst_async_sframe", sframe[0], 1'b0);
    check_val("rst_async_busy", busy[0], 1'b0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #2 rst_n = 1'b1;
    for (int k = 0; k < 40; k++) step(1'b0, 12'd0);

    // Randomized traffic
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 11) == 0, 12'($urandom));
    end
    for (int k = 0; k < 8; k++) step(1'b1, 12'($urandom));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
